// File: rtl/lpf_pkg.sv
// Shared definitions for the multi-channel averaging low-pass filter.
// Holds the mode encoding and the accumulator width helper.
package lpf_pkg;

  typedef enum logic {
    MODE_BLOCK   = 1'b0,
    MODE_SLIDING = 1'b1
  } lpf_mode_e;

  // One extra bit per doubling of the window keeps a full-window sum exact.
  function automatic int acc_width(input int width, input int log2_depth);
    return width + log2_depth;
  endfunction

endpackage

// File: rtl/lpf_channel.sv
// One channel of the averaging filter: block accumulator, circular window,
// running sum and the registered average. Sequencing comes from the top.
module lpf_channel
  import lpf_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  take,
  input  lpf_mode_e             mode,
  input  logic                  load,
  input  logic [LOG2_DEPTH-1:0] wr_ptr,
  input  logic [WIDTH-1:0]      sample,
  output logic [WIDTH-1:0]      avg
);

  localparam int ACC_WIDTH = acc_width(WIDTH, LOG2_DEPTH);
  localparam int DEPTH     = 1 << LOG2_DEPTH;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic        [WIDTH-1:0]     win_q [DEPTH];
  logic        [WIDTH-1:0]     win_d [DEPTH];
  logic        [WIDTH-1:0]     avg_q, avg_d;
  logic signed [ACC_WIDTH-1:0] sample_ext, oldest_ext, acc_new, sum_new;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    sample_ext = {{LOG2_DEPTH{sample[WIDTH-1]}}, sample};
    oldest_ext = {{LOG2_DEPTH{win_q[wr_ptr][WIDTH-1]}}, win_q[wr_ptr]};
    acc_new    = acc_q + sample_ext;
    sum_new    = sum_q + sample_ext - oldest_ext;

    acc_d = acc_q;
    sum_d = sum_q;
    win_d = win_q;
    avg_d = avg_q;

    if (flush) begin
      acc_d = '0;
      sum_d = '0;
      for (int i = 0; i < DEPTH; i++) win_d[i] = '0;
    end else if (take) begin
      if (mode == MODE_BLOCK) begin
        acc_d = load ? '0 : acc_new;
      end else begin
        sum_d         = sum_new;
        win_d[wr_ptr] = sample;
      end
      // Dropping the low LOG2_DEPTH bits equals sum >>> LOG2_DEPTH: floors toward -inf.
      if (load) begin
        avg_d = (mode == MODE_BLOCK) ? acc_new[ACC_WIDTH-1:LOG2_DEPTH]
                                     : sum_new[ACC_WIDTH-1:LOG2_DEPTH];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
      avg_q <= '0;
      // NOTE: the window is reset because the running sum assumes zeroed entries during fill.
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
      avg_q <= avg_d;
      win_q <= win_d;
    end
  end

  assign avg = avg_q;

endmodule

// File: rtl/lpf_multi.sv
// Multi-channel averaging low-pass filter: block (decimating) or sliding-window
// mean per channel. This level owns the shared counters, mode and strobes.
module lpf_multi
  import lpf_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] avg,
  output logic                      primed
);

  localparam logic [LOG2_DEPTH:0] FILL_FULL = {1'b1, {LOG2_DEPTH{1'b0}}};
  localparam logic [LOG2_DEPTH:0] FILL_LAST = FILL_FULL - 1'b1;

  logic [LOG2_DEPTH-1:0] cnt_q, cnt_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH:0]   fill_q, fill_d;
  lpf_mode_e             mode_q, mode_d;
  logic                  armed_q, armed_d;
  logic                  primed_q, primed_d;
  logic                  out_valid_q, out_valid_d;

  lpf_mode_e mode_in, eff_mode;
  logic      flush, take, load;

  always_comb begin
    mode_in = lpf_mode_e'(mode);
    // Until the first post-reset edge mode_q has not sampled the pin yet.
    eff_mode = armed_q ? mode_q : mode_in;
    flush    = armed_q && (mode_in != mode_q);
    take     = in_valid && !flush;
    load     = (eff_mode == MODE_BLOCK) ? (take && (&cnt_q))
                                        : (take && (fill_q >= FILL_LAST));

    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    mode_d      = mode_in;
    armed_d     = 1'b1;
    out_valid_d = load;
    primed_d    = primed_q | load;

    if (flush) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      primed_d = 1'b0;
    end else if (take) begin
      if (eff_mode == MODE_BLOCK) begin
        cnt_d = cnt_q + 1'b1;  // DEPTH is a power of two, so this wraps to 0
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      mode_q      <= MODE_BLOCK;
      armed_q     <= 1'b0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      mode_q      <= mode_d;
      armed_q     <= armed_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Channel 0 occupies the most significant slice of data and avg.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    lpf_channel #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .take   (take),
      .mode   (eff_mode),
      .load   (load),
      .wr_ptr (wr_ptr_q),
      .sample (data[(CHANNELS-1-g)*WIDTH +: WIDTH]),
      .avg    (avg[(CHANNELS-1-g)*WIDTH +: WIDTH])
    );
  end

  assign out_valid = out_valid_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_lpf_multi.sv
// Scoreboard bench for lpf_multi: stimulus pushes hand-computed averages,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_lpf_multi;

  localparam int CH = 3;
  localparam int W  = 16;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic          in_valid;
  logic [CH*W-1:0] data;
  logic          out_valid;
  logic [CH*W-1:0] avg;
  logic          primed;

  int checks   = 0;
  int failures = 0;
  logic [CH*W-1:0] exp_q [$];

  always #5 clk = ~clk;

  lpf_multi #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .LOG2_DEPTH (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .data      (data),
    .out_valid (out_valid),
    .avg       (avg),
    .primed    (primed)
  );

  function automatic logic [CH*W-1:0] pack3(input int x, input int y, input int z);
    return {16'(x), 16'(y), 16'(z)};
  endfunction

  task automatic check(input string name, input logic [CH*W-1:0] act,
                       input logic [CH*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int x, input int y, input int z);
    in_valid = 1'b1;
    data     = pack3(x, y, z);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected average.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) check("spurious_out_valid", {47'd0, out_valid}, '0);
        else                   check("avg_on_out_valid", avg, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    data     = '0;
    #2;
    check("reset_avg", avg, '0);
    check("reset_out_valid", {47'd0, out_valid}, '0);
    check("reset_primed", {47'd0, primed}, '0);
    #10 rst_n = 1'b1;
    idle(1);

    // Block mode: two back-to-back windows, nothing dropped between them.
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_q.push_back(pack3(4, -4, 0));
      send(i, -4, 0);
    end
    check("block_primed", {47'd0, primed}, 48'd1);
    for (int i = 9; i <= 16; i++) begin
      if (i == 16) exp_q.push_back(pack3(12, -4, 0));
      send(i, -4, 0);
    end

    // Block mode with sparse in_valid.
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_q.push_back(pack3(4, -4, 0));
      send(i, -4, 0);
      idle(2);
    end

    // Floor and extremes.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(pack3(-1, 0, 0));
      send((i == 0) ? -1 : 0, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(pack3(32767, 32767, 32767));
      send(32767, 32767, 32767);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(pack3(-32768, -32768, -32768));
      send(-32768, -32768, -32768);
    end

    // Asynchronous reset after 5 of 8 samples.
    for (int i = 0; i < 5; i++) send(2, -2, 5);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_avg", avg, '0);
    check("async_reset_out_valid", {47'd0, out_valid}, '0);
    check("async_reset_primed", {47'd0, primed}, '0);
    #4 rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(pack3(2, -2, 5));
      send(2, -2, 5);
    end

    // Sliding mode.
    mode = 1'b1;
    idle(1);
    check("to_sliding_primed", {47'd0, primed}, '0);
    check("to_sliding_avg_hold", avg, pack3(2, -2, 5));
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_q.push_back(pack3(16, -16, 0));
      send(16, -16, 0);
      if (i == 7) check("sliding_not_primed_7", {47'd0, primed}, '0);
    end
    check("sliding_primed_8", {47'd0, primed}, 48'd1);
    exp_q.push_back(pack3(17, -16, 0));
    send(24, -16, 0);
    exp_q.push_back(pack3(18, -16, 0));
    send(24, -16, 0);

    // Back to block mode, then toggle mid-window with a sample in the toggle cycle.
    mode = 1'b0;
    idle(1);
    check("to_block_primed", {47'd0, primed}, '0);
    check("to_block_avg_hold", avg, pack3(18, -16, 0));
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_q.push_back(pack3(4, -4, 0));
      send(i, -4, 0);
    end
    check("block_avg_four", avg, pack3(4, -4, 0));
    for (int i = 0; i < 3; i++) send(100, 100, 100);
    mode = 1'b1;
    send(1000, 1000, 1000);
    check("toggle_primed", {47'd0, primed}, '0);
    check("toggle_out_valid", {47'd0, out_valid}, '0);
    check("toggle_avg_hold", avg, pack3(4, -4, 0));
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(pack3(40, 8, -8));
      send(40, 8, -8);
    end
    mode = 1'b0;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(pack3(-3, 0, 1));
      send(-3, 0, 1);
    end

    idle(3);
    check("scoreboard_drained", 48'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
